// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_sync_v2 buffer family.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    READ_ONLY  = 2'b01,
    WRITE_ONLY = 2'b10,
    WRITE_READ = 2'b11
  } fifo_op_e;

  // Pointer increment that wraps at an arbitrary (non-power-of-2) depth.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr >= depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_sync_v2_if.sv
// Producer/consumer handshake bundle for fifo_sync_v2; master drives requests, slave is the FIFO.
interface fifo_sync_v2_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             wt_en;
  logic             rd_en;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;
  logic             ovf_sticky;
  logic             udf_sticky;

  modport master (
    output wt_en, rd_en, flush, clr_err, din,
    input  dout, full, empty, almost_full, almost_empty, level,
    input  overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  wt_en, rd_en, flush, clr_err, din,
    output dout, full, empty, almost_full, almost_empty, level,
    output overflow, underflow, ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; flush and rst only move pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, level/threshold flags,
// synchronous flush and pulse + sticky overflow/underflow reporting.
module fifo_sync_v2
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic           clk,
  input logic           rst,
  fifo_sync_v2_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_sync_v2: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_sync_v2: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_sync_v2: AE_THRESH out of range");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $fatal(1, "fifo_sync_v2: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0] wr_p_q, wr_p_d;
  logic [PTR_W-1:0] rd_p_q, rd_p_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             udf_sticky_q, udf_sticky_d;

  logic             full_s, empty_s;
  logic             wr_acc_s, rd_acc_s, mem_we_s;
  logic [WIDTH-1:0] rdata_s;
  fifo_op_e         op_s;

  assign full_s   = (level_q == LVL_W'(DEPTH));
  assign empty_s  = (level_q == LVL_W'(0));
  // Acceptance uses pre-edge flags only: a same-cycle pop never frees room for a push at full.
  assign wr_acc_s = bus.wt_en && !full_s;
  assign rd_acc_s = bus.rd_en && !empty_s;
  assign op_s     = fifo_op_e'({wr_acc_s, rd_acc_s});
  assign mem_we_s = wr_acc_s && !bus.flush;

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_p_q),
    .wdata (bus.din),
    .raddr (rd_p_q),
    .rdata (rdata_s)
  );

  // Next-state for pointers, level and the registered read word.
  always_comb begin
    wr_p_d  = wr_p_q;
    rd_p_d  = rd_p_q;
    level_d = level_q;
    dout_d  = dout_q;
    if (bus.flush) begin
      wr_p_d  = '0;
      rd_p_d  = '0;
      level_d = '0;
      dout_d  = '0;
    end else begin
      case (op_s)
        READ_ONLY: begin
          rd_p_d  = PTR_W'(ptr_wrap_inc(32'(rd_p_q), DEPTH));
          level_d = level_q - LVL_W'(1);
          dout_d  = rdata_s;
        end
        WRITE_ONLY: begin
          wr_p_d  = PTR_W'(ptr_wrap_inc(32'(wr_p_q), DEPTH));
          level_d = level_q + LVL_W'(1);
        end
        WRITE_READ: begin
          wr_p_d  = PTR_W'(ptr_wrap_inc(32'(wr_p_q), DEPTH));
          rd_p_d  = PTR_W'(ptr_wrap_inc(32'(rd_p_q), DEPTH));
          dout_d  = rdata_s;
        end
        default: begin
          level_d = level_q;
        end
      endcase
    end
  end

  // Error pulses follow the raw request against the pre-edge flags; set beats clr_err.
  always_comb begin
    ovf_d        = bus.wt_en && full_s;
    udf_d        = bus.rd_en && empty_s;
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;
    if (ovf_d) begin
      ovf_sticky_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
    if (udf_d) begin
      udf_sticky_d = 1'b1;
    end else if (bus.clr_err) begin
      udf_sticky_d = 1'b0;
    end else begin
      udf_sticky_d = udf_sticky_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p_q       <= '0;
      rd_p_q       <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_p_q       <= wr_p_d;
      rd_p_q       <= rd_p_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // FWFT shows the head word directly and blanks to zero when nothing is stored.
  assign bus.dout         = (FWFT == 1) ? (empty_s ? '0 : rdata_s) : dout_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (level_q >= LVL_W'(AF_THRESH));
  assign bus.almost_empty = (level_q <= LVL_W'(AE_THRESH));
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.ovf_sticky   = ovf_sticky_q;
  assign bus.udf_sticky   = udf_sticky_q;

  a_level_max : assert property (@(posedge clk) disable iff (rst) level_q <= LVL_W'(DEPTH));
  a_not_both  : assert property (@(posedge clk) disable iff (rst) !(full_s && empty_s));
  a_full_eq   : assert property (@(posedge clk) disable iff (rst) full_s == (level_q == LVL_W'(DEPTH)));
  a_empty_eq  : assert property (@(posedge clk) disable iff (rst) empty_s == (level_q == LVL_W'(0)));

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed self-checking bench: DEPTH=16 and DEPTH=12 standard-read FIFOs plus an FWFT instance.
module tb_fifo_sync_v2;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  fifo_sync_v2_if #(.DEPTH(16), .WIDTH(8)) if16 ();
  fifo_sync_v2_if #(.DEPTH(12), .WIDTH(8)) if12 ();
  fifo_sync_v2_if #(.DEPTH(8),  .WIDTH(8)) iff8 ();

  fifo_sync_v2 #(.DEPTH(16), .WIDTH(8), .FWFT(0)) u16 (.clk(clk), .rst(rst), .bus(if16));
  fifo_sync_v2 #(.DEPTH(12), .WIDTH(8), .FWFT(0)) u12 (.clk(clk), .rst(rst), .bus(if12));
  fifo_sync_v2 #(.DEPTH(8),  .WIDTH(8), .FWFT(1)) uf  (.clk(clk), .rst(rst), .bus(iff8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    {if16.wt_en, if16.rd_en, if16.flush, if16.clr_err} = 4'b0000;
    {if12.wt_en, if12.rd_en, if12.flush, if12.clr_err} = 4'b0000;
    {iff8.wt_en, iff8.rd_en, iff8.flush, iff8.clr_err} = 4'b0000;
    if16.din = 8'h00;
    if12.din = 8'h00;
    iff8.din = 8'h00;
    #2;
    chk("rst_level", if16.level, 0);
    chk("rst_empty", if16.empty, 1);
    chk("rst_ae", if16.almost_empty, 1);
    chk("rst_full", if16.full, 0);
    chk("rst_af", if16.almost_full, 0);
    chk("rst_dout", if16.dout, 0);
    chk("rst_ovf", {if16.overflow, if16.underflow, if16.ovf_sticky, if16.udf_sticky}, 0);
    chk("rst_f_dout", iff8.dout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill DEPTH=16 with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      if16.wt_en = 1'b1;
      if16.din   = 8'(i);
      tick();
      chk("fill_level", if16.level, i + 1);
      chk("fill_af", if16.almost_full, (i + 1 >= 14));
    end
    chk("fill_full", if16.full, 1);
    chk("fill_empty", if16.empty, 0);
    if16.din = 8'hFF;
    tick();
    chk("ovf_pulse", if16.overflow, 1);
    chk("ovf_sticky", if16.ovf_sticky, 1);
    chk("ovf_level", if16.level, 16);
    if16.wt_en = 1'b0;
    tick();
    chk("ovf_pulse_end", if16.overflow, 0);
    chk("ovf_sticky_hold", if16.ovf_sticky, 1);

    // Drain in order, one cycle read latency
    for (int i = 0; i < 16; i++) begin
      if16.rd_en = 1'b1;
      tick();
      chk("drain_dout", if16.dout, i);
      chk("drain_level", if16.level, 15 - i);
      chk("drain_ae", if16.almost_empty, (15 - i <= 2));
    end
    if16.rd_en = 1'b0;
    tick();
    chk("drain_empty", if16.empty, 1);
    chk("drain_hold", if16.dout, 8'h0F);
    chk("drain_udf", if16.underflow, 0);

    // DEPTH=12: prime to level 5 then 30 cycles of simultaneous write/read
    for (int i = 0; i < 5; i++) begin
      if12.wt_en = 1'b1;
      if12.din   = 8'(i);
      tick();
    end
    chk("d12_prime", if12.level, 5);
    for (int k = 0; k < 30; k++) begin
      if12.wt_en = 1'b1;
      if12.rd_en = 1'b1;
      if12.din   = 8'(k + 5);
      tick();
      chk("d12_dout", if12.dout, k);
      chk("d12_level", if12.level, 5);
    end
    if12.wt_en = 1'b0;
    if12.rd_en = 1'b0;

    // FWFT single word
    chk("fw_empty0", iff8.empty, 1);
    iff8.wt_en = 1'b1;
    iff8.din   = 8'hA5;
    tick();
    iff8.wt_en = 1'b0;
    chk("fw_empty", iff8.empty, 0);
    chk("fw_dout", iff8.dout, 8'hA5);
    iff8.rd_en = 1'b1;
    tick();
    chk("fw_pop_empty", iff8.empty, 1);
    chk("fw_pop_dout", iff8.dout, 0);

    // Read at empty with a write: write lands, read rejected
    iff8.wt_en = 1'b1;
    iff8.rd_en = 1'b1;
    iff8.din   = 8'h3C;
    tick();
    chk("udf_level", iff8.level, 1);
    chk("udf_pulse", iff8.underflow, 1);
    chk("udf_sticky", iff8.udf_sticky, 1);
    chk("udf_dout", iff8.dout, 8'h3C);
    iff8.wt_en = 1'b0;
    iff8.rd_en = 1'b0;
    tick();
    chk("udf_pulse_end", iff8.underflow, 0);
    iff8.rd_en = 1'b1;
    tick();
    chk("udf_pop_level", iff8.level, 0);
    chk("udf_pop_pulse", iff8.underflow, 0);
    iff8.clr_err = 1'b1;
    tick();
    chk("clr_vs_set_pulse", iff8.underflow, 1);
    chk("clr_vs_set_sticky", iff8.udf_sticky, 1);
    iff8.rd_en = 1'b0;
    tick();
    chk("clr_sticky", iff8.udf_sticky, 0);
    iff8.clr_err = 1'b0;

    // Flush at level 9 overrides same-cycle write and read
    for (int i = 0; i < 9; i++) begin
      if16.wt_en = 1'b1;
      if16.din   = 8'(8'h20 + i);
      tick();
    end
    chk("fl_pre_level", if16.level, 9);
    if16.flush = 1'b1;
    if16.rd_en = 1'b1;
    if16.din   = 8'hEE;
    tick();
    {if16.flush, if16.rd_en, if16.wt_en} = 3'b000;
    chk("fl_level", if16.level, 0);
    chk("fl_empty", if16.empty, 1);
    chk("fl_dout", if16.dout, 0);
    chk("fl_ovf_sticky", if16.ovf_sticky, 1);
    chk("fl_udf_sticky", if16.udf_sticky, 0);
    if16.wt_en = 1'b1;
    if16.din   = 8'h55;
    tick();
    if16.wt_en = 1'b0;
    if16.rd_en = 1'b1;
    tick();
    if16.rd_en = 1'b0;
    chk("fl_after_dout", if16.dout, 8'h55);
    chk("fl_after_level", if16.level, 0);

    // Async reset mid-burst at level 7
    for (int i = 0; i < 7; i++) begin
      if16.wt_en = 1'b1;
      if16.din   = 8'(8'h70 + i);
      tick();
    end
    chk("ar_pre_level", if16.level, 7);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_level", if16.level, 0);
    chk("ar_empty", if16.empty, 1);
    chk("ar_ae", if16.almost_empty, 1);
    chk("ar_dout", if16.dout, 0);
    chk("ar_flags", {if16.full, if16.almost_full, if16.overflow, if16.ovf_sticky}, 0);
    if16.wt_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if16.wt_en = 1'b1;
    if16.din   = 8'h99;
    tick();
    if16.wt_en = 1'b0;
    chk("ar_post_level", if16.level, 1);
    chk("ar_post_addr0", u16.u_mem.mem[0], 8'h99);
    if16.rd_en = 1'b1;
    tick();
    if16.rd_en = 1'b0;
    chk("ar_post_dout", if16.dout, 8'h99);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
